idex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand forwarding for the pipelined RISC-V core.
- Captures decoded fields each cycle and resolves RAW hazards by forwarding from MEM/WB.
- Drives the ALU inputs a, b and alucontrol[2:0] directly.
- Detects load-use hazards and inserts bubbles; honours downstream hold and branch flush.

---
 rtl/idex_operand_stage_if.sv | 42 ++++
 rtl/idex_operand_stage.sv | 104 ++++++++++
 tb/tb_idex_operand_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/idex_operand_stage_if.sv
// Decode-side inputs, MEM/WB forwarding sources and EX-side outputs of the ID/EX operand stage.
interface idex_operand_stage_if #(
    parameter int XLEN    = 32,
    parameter int REGBITS = 5
);
    logic               valid_d;
    logic [REGBITS-1:0] rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0]    rd1_d, rd2_d, immext_d, pc_d;
    logic               alusrc_d;
    logic [2:0]         alucontrol_d;
    logic               regwrite_d, memwrite_d, branch_d, jump_d;
    logic [1:0]         resultsrc_d;
    logic               hold_e, flush_e;
    logic [REGBITS-1:0] rd_m, rd_w;
    logic               regwrite_m, regwrite_w;
    logic [XLEN-1:0]    aluresult_m, result_w;

    logic               stall_d;
    logic [XLEN-1:0]    srca_e, srcb_e, writedata_e, pctarget_e;
    logic [2:0]         alucontrol_e;
    logic [REGBITS-1:0] rd_e;
    logic               valid_e, regwrite_e, memwrite_e, branch_e, jump_e;
    logic [1:0]         resultsrc_e, forwarda_e, forwardb_e;

    modport master (
        output valid_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, immext_d, pc_d, alusrc_d,
               alucontrol_d, regwrite_d, memwrite_d, branch_d, jump_d, resultsrc_d,
               hold_e, flush_e, rd_m, regwrite_m, aluresult_m, rd_w, regwrite_w, result_w,
        input  stall_d, srca_e, srcb_e, alucontrol_e, writedata_e, pctarget_e, rd_e,
               valid_e, regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e,
               forwarda_e, forwardb_e
    );

    modport slave (
        input  valid_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, immext_d, pc_d, alusrc_d,
               alucontrol_d, regwrite_d, memwrite_d, branch_d, jump_d, resultsrc_d,
               hold_e, flush_e, rd_m, regwrite_m, aluresult_m, rd_w, regwrite_w, result_w,
        output stall_d, srca_e, srcb_e, alucontrol_e, writedata_e, pctarget_e, rd_e,
               valid_e, regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e,
               forwarda_e, forwardb_e
    );
endinterface

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
module idex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int REGBITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    idex_operand_stage_if.slave bus
);
    typedef struct packed {
        logic               valid;
        logic [REGBITS-1:0] rs1, rs2, rd;
        logic [XLEN-1:0]    rd1, rd2, imm, pc;
        logic               alusrc;
        logic [2:0]         aluctl;
        logic               regwrite, memwrite, branch, jump;
        logic [1:0]         resultsrc;
    } ex_t;

    ex_t  ex_q, ex_d, dec;
    logic lwstall;

    always_comb begin
        dec           = '0;
        dec.valid     = bus.valid_d;
        dec.rs1       = bus.rs1_d;
        dec.rs2       = bus.rs2_d;
        dec.rd        = bus.rd_d;
        dec.rd1       = bus.rd1_d;
        dec.rd2       = bus.rd2_d;
        dec.imm       = bus.immext_d;
        dec.pc        = bus.pc_d;
        dec.alusrc    = bus.alusrc_d;
        dec.aluctl    = bus.alucontrol_d;
        dec.regwrite  = bus.regwrite_d;
        dec.memwrite  = bus.memwrite_d;
        dec.branch    = bus.branch_d;
        dec.jump      = bus.jump_d;
        dec.resultsrc = bus.resultsrc_d;
    end

    // A load in EX whose destination is read by the instruction in decode cannot be forwarded in time.
    assign lwstall = ex_q.valid & ex_q.regwrite & (ex_q.resultsrc == 2'b01) &
                     (ex_q.rd != '0) & bus.valid_d &
                     ((ex_q.rd == bus.rs1_d) | (ex_q.rd == bus.rs2_d));

    assign bus.stall_d = lwstall | bus.hold_e;

    // Hold wins over flush/lwstall so a frozen EX slot is never replaced by a bubble.
    always_comb begin
        ex_d = ex_q;
        if (!bus.hold_e) begin
            if (bus.flush_e || lwstall) ex_d = '0;
            else                        ex_d = dec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ex_q <= '0;
        else          ex_q <= ex_d;
    end

    logic [XLEN-1:0] fwd_a, fwd_b;
    logic [1:0]      sel_a, sel_b;

    always_comb begin
        sel_a = 2'b00;
        fwd_a = ex_q.rd1;
        if (bus.regwrite_m && bus.rd_m != '0 && bus.rd_m == ex_q.rs1) begin
            sel_a = 2'b10;
            fwd_a = bus.aluresult_m;
        end else if (bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == ex_q.rs1) begin
            sel_a = 2'b01;
            fwd_a = bus.result_w;
        end
    end

    always_comb begin
        sel_b = 2'b00;
        fwd_b = ex_q.rd2;
        if (bus.regwrite_m && bus.rd_m != '0 && bus.rd_m == ex_q.rs2) begin
            sel_b = 2'b10;
            fwd_b = bus.aluresult_m;
        end else if (bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == ex_q.rs2) begin
            sel_b = 2'b01;
            fwd_b = bus.result_w;
        end
    end

    assign bus.srca_e       = fwd_a;
    assign bus.writedata_e  = fwd_b;
    assign bus.srcb_e       = ex_q.alusrc ? ex_q.imm : fwd_b;
    assign bus.forwarda_e   = sel_a;
    assign bus.forwardb_e   = sel_b;
    assign bus.pctarget_e   = ex_q.pc + ex_q.imm;
    assign bus.alucontrol_e = ex_q.aluctl;
    assign bus.rd_e         = ex_q.rd;
    assign bus.valid_e      = ex_q.valid;
    assign bus.regwrite_e   = ex_q.regwrite;
    assign bus.memwrite_e   = ex_q.memwrite;
    assign bus.branch_e     = ex_q.branch;
    assign bus.jump_e       = ex_q.jump;
    assign bus.resultsrc_e  = ex_q.resultsrc;
endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: vector table for forwarding/operand muxing plus hazard sequences.
module tb_idex_operand_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    idex_operand_stage_if #(.XLEN(32), .REGBITS(5)) bus ();
    idex_operand_stage #(.XLEN(32), .REGBITS(5)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        bus.valid_d = 0; bus.rs1_d = 0; bus.rs2_d = 0; bus.rd_d = 0;
        bus.rd1_d = 0; bus.rd2_d = 0; bus.immext_d = 0; bus.pc_d = 0;
        bus.alusrc_d = 0; bus.alucontrol_d = 0; bus.regwrite_d = 0; bus.memwrite_d = 0;
        bus.branch_d = 0; bus.jump_d = 0; bus.resultsrc_d = 0;
        bus.hold_e = 0; bus.flush_e = 0;
        bus.rd_m = 0; bus.regwrite_m = 0; bus.aluresult_m = 0;
        bus.rd_w = 0; bus.regwrite_w = 0; bus.result_w = 0;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rd1, rd2, imm, pc;
        logic        alusrc;
        logic [2:0]  aluctl;
        logic [4:0]  rd_m;
        logic        rwm;
        logic [31:0] alu_m;
        logic [4:0]  rd_w;
        logic        rww;
        logic [31:0] res_w;
        logic [31:0] e_srca, e_srcb, e_wd, e_pct;
        logic [1:0]  e_fa, e_fb;
    } vec_t;

    vec_t vec [6];

    initial begin
        // rs1 rs2 rd1 rd2 imm pc alusrc aluctl | rd_m rwm alu_m rd_w rww res_w | srca srcb wd pct fa fb
        vec[0] = '{5'd1, 5'd2, 32'd5, 32'd7, 32'h10, 32'h100, 1'b0, 3'b000,
                   5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
                   32'd5, 32'd7, 32'd7, 32'h110, 2'b00, 2'b00};
        vec[1] = '{5'd3, 5'd5, 32'd1, 32'd2, 32'h0, 32'h200, 1'b0, 3'b001,
                   5'd3, 1'b1, 32'h11, 5'd3, 1'b1, 32'h22,
                   32'h11, 32'd2, 32'd2, 32'h200, 2'b10, 2'b00};
        vec[2] = '{5'd3, 5'd5, 32'd1, 32'd2, 32'h0, 32'h200, 1'b0, 3'b001,
                   5'd3, 1'b0, 32'h11, 5'd3, 1'b1, 32'h22,
                   32'h22, 32'd2, 32'd2, 32'h200, 2'b01, 2'b00};
        vec[3] = '{5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFC, 32'h0, 1'b1, 3'b010,
                   5'd0, 1'b1, 32'h55, 5'd0, 1'b1, 32'h66,
                   32'h0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 2'b00, 2'b00};
        vec[4] = '{5'd6, 5'd7, 32'd9, 32'hA, 32'h20, 32'hFFFFFFF0, 1'b1, 3'b011,
                   5'd7, 1'b1, 32'h77, 5'd0, 1'b0, 32'h0,
                   32'd9, 32'h20, 32'h77, 32'h10, 2'b00, 2'b10};
        vec[5] = '{5'd9, 5'd8, 32'd1, 32'd2, 32'h4, 32'h300, 1'b0, 3'b101,
                   5'd9, 1'b1, 32'h99, 5'd8, 1'b1, 32'h88,
                   32'h99, 32'h88, 32'h88, 32'h304, 2'b10, 2'b01};

        clear_all();
        #2;
        chk("rst_valid", 32'(bus.valid_e), 0);
        chk("rst_srca", bus.srca_e, 0);
        chk("rst_pct", bus.pctarget_e, 0);
        chk("rst_fwda", 32'(bus.forwarda_e), 0);
        chk("rst_stall", 32'(bus.stall_d), 0);
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            bus.valid_d = 1; bus.regwrite_d = 1; bus.rd_d = 5'(i + 10);
            bus.rs1_d = vec[i].rs1; bus.rs2_d = vec[i].rs2;
            bus.rd1_d = vec[i].rd1; bus.rd2_d = vec[i].rd2;
            bus.immext_d = vec[i].imm; bus.pc_d = vec[i].pc;
            bus.alusrc_d = vec[i].alusrc; bus.alucontrol_d = vec[i].aluctl;
            bus.regwrite_m = 0; bus.regwrite_w = 0;
            step();
            bus.rd_m = vec[i].rd_m; bus.regwrite_m = vec[i].rwm; bus.aluresult_m = vec[i].alu_m;
            bus.rd_w = vec[i].rd_w; bus.regwrite_w = vec[i].rww; bus.result_w = vec[i].res_w;
            #1;
            chk($sformatf("v%0d_srca", i), bus.srca_e, vec[i].e_srca);
            chk($sformatf("v%0d_srcb", i), bus.srcb_e, vec[i].e_srcb);
            chk($sformatf("v%0d_wdata", i), bus.writedata_e, vec[i].e_wd);
            chk($sformatf("v%0d_pct", i), bus.pctarget_e, vec[i].e_pct);
            chk($sformatf("v%0d_fwda", i), 32'(bus.forwarda_e), 32'(vec[i].e_fa));
            chk($sformatf("v%0d_fwdb", i), 32'(bus.forwardb_e), 32'(vec[i].e_fb));
            chk($sformatf("v%0d_aluctl", i), 32'(bus.alucontrol_e), 32'(vec[i].aluctl));
            chk($sformatf("v%0d_rd", i), 32'(bus.rd_e), i + 10);
            chk($sformatf("v%0d_valid", i), 32'(bus.valid_e), 1);
        end

        // Asynchronous reset in the middle of operation, then a plain add.
        clear_all();
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.valid_e), 0);
        chk("arst_srcb", bus.srcb_e, 0);
        chk("arst_rd", 32'(bus.rd_e), 0);
        chk("arst_regwrite", 32'(bus.regwrite_e), 0);
        #2;
        reset_n = 1'b1;
        bus.valid_d = 1; bus.regwrite_d = 1; bus.rs1_d = 1; bus.rs2_d = 2; bus.rd_d = 3;
        bus.rd1_d = 5; bus.rd2_d = 7; bus.alucontrol_d = 3'b000;
        step();
        chk("add_srca", bus.srca_e, 5);
        chk("add_srcb", bus.srcb_e, 7);
        chk("add_aluctl", 32'(bus.alucontrol_e), 0);
        chk("add_valid", 32'(bus.valid_e), 1);

        // Load-use: lw x4 in EX, consumer reads x4 through rs2.
        clear_all();
        bus.valid_d = 1; bus.regwrite_d = 1; bus.resultsrc_d = 2'b01;
        bus.rs1_d = 1; bus.rs2_d = 2; bus.rd_d = 4;
        step();
        chk("lw_in_ex_rs", 32'(bus.resultsrc_e), 1);
        clear_all();
        bus.valid_d = 1; bus.regwrite_d = 1; bus.rs1_d = 0; bus.rs2_d = 4; bus.rd_d = 6;
        bus.rd2_d = 32'h44;
        #1;
        chk("lu_stall", 32'(bus.stall_d), 1);
        step();
        chk("lu_bubble_valid", 32'(bus.valid_e), 0);
        chk("lu_bubble_rd", 32'(bus.rd_e), 0);
        chk("lu_bubble_rw", 32'(bus.regwrite_e), 0);
        chk("lu_stall_clear", 32'(bus.stall_d), 0);
        step();
        chk("lu_enter_valid", 32'(bus.valid_e), 1);
        chk("lu_enter_rd", 32'(bus.rd_e), 6);
        chk("lu_enter_wdata", bus.writedata_e, 32'h44);
        chk("lu_enter_stall", 32'(bus.stall_d), 0);

        // Flush kills the incoming decode slot.
        clear_all();
        bus.valid_d = 1; bus.regwrite_d = 1; bus.rd_d = 7; bus.branch_d = 1;
        step();
        chk("pre_flush_branch", 32'(bus.branch_e), 1);
        bus.flush_e = 1; bus.rd_d = 8; bus.jump_d = 1; bus.branch_d = 0;
        step();
        chk("flush_valid", 32'(bus.valid_e), 0);
        chk("flush_rd", 32'(bus.rd_e), 0);
        chk("flush_jump", 32'(bus.jump_e), 0);

        // Hold beats flush; forwarding still tracks MEM during the hold.
        clear_all();
        bus.valid_d = 1; bus.regwrite_d = 1; bus.memwrite_d = 1; bus.rd_d = 9;
        bus.rs1_d = 3; bus.rd1_d = 32'h31;
        step();
        bus.hold_e = 1; bus.flush_e = 1;
        bus.rd_d = 10; bus.rs1_d = 2; bus.rd1_d = 32'h55; bus.memwrite_d = 0;
        #1;
        chk("hold_stall", 32'(bus.stall_d), 1);
        step();
        chk("hold_valid", 32'(bus.valid_e), 1);
        chk("hold_rd", 32'(bus.rd_e), 9);
        chk("hold_memwrite", 32'(bus.memwrite_e), 1);
        chk("hold_srca", bus.srca_e, 32'h31);
        bus.rd_m = 3; bus.regwrite_m = 1; bus.aluresult_m = 32'hABC;
        #1;
        chk("hold_fwd_srca", bus.srca_e, 32'hABC);
        chk("hold_fwd_sel", 32'(bus.forwarda_e), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
